// File: rtl/vliw_pkg.sv
// Shared VLIW definitions: bundle geometry, the NOP used to pad
// partially filled bundles, and the state type of the boot loader.
package vliw_pkg;

  localparam int          BUNDLE_W = 128;
  localparam int          SLOTS    = 4;
  localparam int          SLOT_W   = 2;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    LOAD,
    FLUSH,
    DONE,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/bundle_loader.sv
// bundle_loader: boot-time program loader.
// Packs a stream of 32-bit instruction words into 128-bit bundles and writes
// each bundle to BASE_ADDR + 16*index. The core is held in reset until the
// last bundle has been written.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_valid/s_data/s_last/s_ready  word stream (transfer on s_valid && s_ready)
//   mem_wr_en/addr/data            registered one-cycle bundle write
//   core_rst          high until the image is fully loaded
//   done / error      sticky completion / overflow flags
//   bundle_count      bundles written so far
//
// BASE_ADDR must be 16-byte aligned; 1 <= MAX_BUNDLES < 65536.
module bundle_loader
  import vliw_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MAX_BUNDLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  input  logic [31:0]         s_data,
  input  logic                s_last,
  output logic                s_ready,
  output logic                mem_wr_en,
  output logic [31:0]         mem_wr_addr,
  output logic [BUNDLE_W-1:0] mem_wr_data,
  output logic                core_rst,
  output logic                done,
  output logic                error,
  output logic [15:0]         bundle_count
);

  localparam logic [15:0] MAX_IDX = 16'(MAX_BUNDLES);

  loader_state_t       state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [15:0]         index_q, index_d;
  logic [BUNDLE_W-1:0] asm_q, asm_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [31:0]         mem_wr_addr_q, mem_wr_addr_d;
  logic [BUNDLE_W-1:0] mem_wr_data_q, mem_wr_data_d;

  logic                full;
  logic [SLOTS-1:0]    below_slot;
  logic [BUNDLE_W-1:0] bundle_fill;

  // Image capacity is reached only on a bundle boundary, so the check
  // only needs to look at slot 0.
  assign full = (index_q == MAX_IDX) && (slot_q == '0);

  // Bundle as it would look if the current word completed it: earlier slots
  // from the assembly register, the incoming word in its slot, NOPs above.
  assign below_slot = (4'b0001 << slot_q) - 4'b0001;

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    assign bundle_fill[32*gi +: 32] = below_slot[gi]           ? asm_q[32*gi +: 32] :
                                      (slot_q == SLOT_W'(gi))  ? s_data             :
                                                                 NOP_INST;
  end

  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    index_d       = index_q;
    asm_d         = asm_q;
    mem_wr_en_d   = 1'b0;
    mem_wr_addr_d = mem_wr_addr_q;
    mem_wr_data_d = mem_wr_data_q;

    case (state_q)
      LOAD: begin
        if (s_valid) begin
          if (full) begin
            state_d = ERROR;
          end else begin
            asm_d = bundle_fill;
            if (slot_q == SLOT_W'(SLOTS - 1) || s_last) begin
              mem_wr_en_d   = 1'b1;
              mem_wr_addr_d = BASE_ADDR + {12'd0, index_q, 4'd0};
              mem_wr_data_d = bundle_fill;
              index_d       = index_q + 16'd1;
              slot_d        = '0;
            end else begin
              slot_d = slot_q + 1'b1;
            end
            if (s_last) begin
              state_d = FLUSH;
            end
          end
        end
      end
      // The final write is on the bus during this state.
      FLUSH:   state_d = DONE;
      DONE:    state_d = DONE;
      ERROR:   state_d = ERROR;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      slot_q        <= '0;
      index_q       <= '0;
      asm_q         <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= BASE_ADDR;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      index_q       <= index_d;
      asm_q         <= asm_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_wr_addr_q <= mem_wr_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

  // s_ready is gated by rst so no word is taken in a reset cycle.
  assign s_ready      = !rst && (state_q == LOAD) && !full;
  assign mem_wr_en    = mem_wr_en_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign core_rst     = (state_q != DONE);
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign bundle_count = index_q;

endmodule

// File: tb/tb_bundle_loader.sv
module tb_bundle_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        sel = 1'b0;   // 0: default DUT, 1: MAX_BUNDLES=2 DUT

  logic a_valid, b_valid;
  assign a_valid = s_valid && !sel;
  assign b_valid = s_valid && sel;

  logic a_ready, a_en, a_core_rst, a_done, a_error;
  logic [31:0] a_addr;
  logic [127:0] a_data;
  logic [15:0] a_count;
  logic b_ready, b_en, b_core_rst, b_done, b_error;
  logic [31:0] b_addr;
  logic [127:0] b_data;
  logic [15:0] b_count;

  bundle_loader #(.BASE_ADDR(32'h0), .MAX_BUNDLES(1024)) dut (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(a_ready), .mem_wr_en(a_en), .mem_wr_addr(a_addr), .mem_wr_data(a_data),
    .core_rst(a_core_rst), .done(a_done), .error(a_error), .bundle_count(a_count)
  );

  bundle_loader #(.BASE_ADDR(32'h0), .MAX_BUNDLES(2)) dut_small (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(b_ready), .mem_wr_en(b_en), .mem_wr_addr(b_addr), .mem_wr_data(b_data),
    .core_rst(b_core_rst), .done(b_done), .error(b_error), .bundle_count(b_count)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          writes_seen = 0;
  logic        last_hs = 1'b0;
  logic [31:0] m_words[4];
  int          m_slot = 0;
  int          m_index = 0;

  // Selected-DUT views
  function automatic logic o_ready();    return sel ? b_ready    : a_ready;    endfunction
  function automatic logic o_en();       return sel ? b_en       : a_en;       endfunction
  function automatic logic o_core_rst(); return sel ? b_core_rst : a_core_rst; endfunction
  function automatic logic o_done();     return sel ? b_done     : a_done;     endfunction
  function automatic logic o_error();    return sel ? b_error    : a_error;    endfunction
  function automatic logic [31:0]  o_addr();  return sel ? b_addr  : a_addr;  endfunction
  function automatic logic [127:0] o_data();  return sel ? b_data  : a_data;  endfunction
  function automatic logic [15:0]  o_count(); return sel ? b_count : a_count; endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_bundle(input int upto);
    logic [127:0] d;
    for (int s = 0; s < 4; s++) d[32*s +: 32] = (s <= upto) ? m_words[s] : NOP;
    return d;
  endfunction

  // One clock: detect handshake, update model/scoreboard, check any write.
  task automatic tick();
    logic hs_now;
    exp_t e;
    hs_now = s_valid && o_ready() && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      m_slot  = 0;
      m_index = 0;
      exp_q.delete();
    end else if (hs_now) begin
      m_words[m_slot] = s_data;
      if (m_slot == 3 || s_last) begin
        e.addr = 32'(m_index * 16);
        e.data = pack_bundle(m_slot);
        e.cyc  = cyc;
        exp_q.push_back(e);
        m_index++;
        m_slot = 0;
      end else begin
        m_slot++;
      end
    end
    last_hs = hs_now;
    if (o_en()) begin
      writes_seen++;
      chk("write_expected", 1'(exp_q.size() != 0), 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", o_addr(), e.addr);
        chk("wr_data", o_data(), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    $display("cyc %0d sel %0d valid %0b ready %0b hs %0b wr %0b addr %h done %0b err %0b cnt %0d",
             cyc, sel, s_valid, o_ready(), hs_now, o_en(), o_addr(), o_done(), o_error(), o_count());
  endtask

  task automatic send(input logic [31:0] d, input logic l, input int gap);
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    last_hs = 1'b0;
    for (int n = 0; n < 50 && !last_hs; n++) tick();
    chk("hs_timeout", last_hs, 1'b1);
  endtask

  task automatic do_reset(input logic check_vals);
    rst = 1'b1;
    tick();
    if (check_vals) begin
      chk("rst_ready", o_ready(), 1'b0);
      chk("rst_wr_en", o_en(), 1'b0);
      chk("rst_addr", o_addr(), 32'h0);
      chk("rst_data", o_data(), 128'h0);
      chk("rst_core_rst", o_core_rst(), 1'b1);
      chk("rst_done", o_done(), 1'b0);
      chk("rst_error", o_error(), 1'b0);
      chk("rst_count", o_count(), 16'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    rst = 1'b0;
    #1;
    if (check_vals) chk("ready_after_rst", o_ready(), 1'b1);
    writes_seen = 0;
  endtask

  initial begin
    // T1: 8 words, s_valid held high, s_last on word 8
    do_reset(1'b1);
    for (int i = 1; i <= 8; i++) send(32'(i), i == 8, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("t1_done_during_write", o_done(), 1'b0);
    tick();
    chk("t1_done", o_done(), 1'b1);
    chk("t1_core_rst", o_core_rst(), 1'b0);
    chk("t1_count", o_count(), 16'd2);
    chk("t1_writes", writes_seen, 2);

    // T6: s_valid in DONE is ignored
    s_valid = 1'b1;
    s_data  = 32'hBAD0_0BAD;
    for (int i = 0; i < 3; i++) begin
      chk("t6_ready", o_ready(), 1'b0);
      tick();
      chk("t6_no_write", o_en(), 1'b0);
      chk("t6_done", o_done(), 1'b1);
    end
    chk("t6_writes", writes_seen, 2);

    // T2: 5 words, final bundle padded with NOPs
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) send(32'hA + 32'(i), i == 4, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("t2_last_data", o_data(), {NOP, NOP, NOP, 32'hE});
    chk("t2_last_addr", o_addr(), 32'h10);
    tick();
    chk("t2_done", o_done(), 1'b1);
    chk("t2_core_rst", o_core_rst(), 1'b0);
    chk("t2_writes", writes_seen, 2);

    // T3: overflow on the MAX_BUNDLES=2 instance
    sel = 1'b1;
    do_reset(1'b0);
    for (int i = 1; i <= 8; i++) send(32'(i), 1'b0, 0);
    s_data = 32'h9;
    chk("t3_ready_full", o_ready(), 1'b0);
    chk("t3_error_before", o_error(), 1'b0);
    tick();
    chk("t3_error", o_error(), 1'b1);
    chk("t3_core_rst", o_core_rst(), 1'b1);
    chk("t3_count", o_count(), 16'd2);
    repeat (3) tick();
    s_valid = 1'b0;
    chk("t3_error_sticky", o_error(), 1'b1);
    chk("t3_done", o_done(), 1'b0);
    chk("t3_writes", writes_seen, 2);
    sel = 1'b0;

    // T4: random s_valid gaps, 12 words
    do_reset(1'b0);
    for (int i = 0; i < 12; i++) send(32'h100 + 32'(i), i == 11, $urandom_range(0, 3));
    s_valid = 1'b0;
    s_last  = 1'b0;
    tick();
    chk("t4_done", o_done(), 1'b1);
    chk("t4_count", o_count(), 16'd3);
    chk("t4_writes", writes_seen, 3);

    // T5: reset after word 6 (with a word offered during reset), then 4 words
    do_reset(1'b0);
    for (int i = 1; i <= 6; i++) send(32'(i), 1'b0, 0);
    s_data = 32'hDEAD;
    do_reset(1'b0);
    chk("t5_count_after_rst", o_count(), 16'd0);
    for (int i = 0; i < 4; i++) send(32'h21 + 32'(i), i == 3, 0);
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("t5_addr", o_addr(), 32'h0);
    chk("t5_data", o_data(), {32'h24, 32'h23, 32'h22, 32'h21});
    repeat (3) tick();
    chk("t5_done", o_done(), 1'b1);
    chk("t5_writes", writes_seen, 1);
    chk("scoreboard_empty", 1'(exp_q.size() == 0), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
